// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction memory port, redirect from execute, and the
// valid/ready hand-off of {pc, instr} to decode.
interface fetch_stage_if #(
  parameter int unsigned D_WIDTH = 32
);
  logic [D_WIDTH-1:0] imem_addr;
  logic [D_WIDTH-1:0] imem_rdata;
  logic               redirect;
  logic [D_WIDTH-1:0] redirect_pc;
  logic               out_valid;
  logic               out_ready;
  logic [D_WIDTH-1:0] out_instr;
  logic [D_WIDTH-1:0] out_pc;
  logic [D_WIDTH-1:0] out_pc4;

  modport master (
    output imem_addr, out_valid, out_instr, out_pc, out_pc4,
    input  imem_rdata, redirect, redirect_pc, out_ready
  );

  modport slave (
    input  imem_addr, out_valid, out_instr, out_pc, out_pc4,
    output imem_rdata, redirect, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the fetch PC, buffers {pc, instr} pairs in a small
// FIFO toward decode, and flushes/restarts on a taken branch or jump.
module fetch_stage #(
  parameter int unsigned        D_WIDTH  = 32,
  parameter int unsigned        DEPTH    = 2,
  parameter logic [D_WIDTH-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);
  localparam int unsigned        PTR_W   = $clog2(DEPTH);
  localparam int unsigned        CNT_W   = $clog2(DEPTH + 1);
  localparam logic [D_WIDTH-1:0] NOP     = D_WIDTH'(32'h0000_0013);
  localparam logic [D_WIDTH-1:0] PC_STEP = D_WIDTH'(4);
  localparam logic [D_WIDTH-1:0] ALIGN   = ~D_WIDTH'(3);

  logic [D_WIDTH-1:0] fetch_pc;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;
  logic [D_WIDTH-1:0] pc_mem    [DEPTH];
  logic [D_WIDTH-1:0] instr_mem [DEPTH];

  logic valid_c;
  logic pop_c;
  logic push_c;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    valid_c = (count != '0);
    pop_c   = valid_c & bus.out_ready;
    push_c  = !bus.redirect & ((count < CNT_W'(DEPTH)) | pop_c);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (bus.redirect) begin
      fetch_pc <= bus.redirect_pc & ALIGN;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push_c) begin
        wr_ptr   <= wr_ptr + PTR_W'(1);
        fetch_pc <= fetch_pc + PC_STEP;
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push_c) - CNT_W'(pop_c);
    end
  end

  // Storage needs no reset; entries are only read while count covers them.
  always_ff @(posedge clk) begin
    if (push_c) begin
      pc_mem[wr_ptr]    <= fetch_pc;
      instr_mem[wr_ptr] <= bus.imem_rdata;
    end
  end

  assign bus.imem_addr = fetch_pc;
  assign bus.out_valid = valid_c;
  assign bus.out_instr = valid_c ? instr_mem[rd_ptr] : NOP;
  assign bus.out_pc    = valid_c ? pc_mem[rd_ptr] : '0;
  assign bus.out_pc4   = valid_c ? pc_mem[rd_ptr] + PC_STEP : '0;
endmodule
